// File: rtl/baud_rate_gen.sv
// Baud-rate tick generator: bit-rate and oversampled strobes from
// two independent dividers that restart whenever enable drops.
module baud_rate_gen #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLING = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick,
  output logic tick_16x
);

  // Guarded operands keep elaboration alive long enough to report.
  localparam int BR  = (BAUD_RATE > 0) ? BAUD_RATE : 1;
  localparam int OVS = (OVERSAMPLING > 0) ? OVERSAMPLING : 1;

  localparam int BAUD_DIV_RAW = CLK_FREQ_HZ / BR - 1;
  localparam int DIV_16X_RAW  = CLK_FREQ_HZ / (BR * OVS) - 1;

  localparam int BAUD_DIV =
    (BAUD_DIV_RAW > 0) ? BAUD_DIV_RAW : 0;
  localparam int BAUD_DIV_16X =
    (DIV_16X_RAW > 0) ? DIV_16X_RAW : 0;

  localparam int CW =
    (BAUD_DIV > 0) ? $clog2(BAUD_DIV + 1) : 1;
  localparam int CW16 =
    (BAUD_DIV_16X > 0) ? $clog2(BAUD_DIV_16X + 1) : 1;

  localparam logic [CW-1:0]   CMAX   = CW'(BAUD_DIV);
  localparam logic [CW16-1:0] CMAX16 = CW16'(BAUD_DIV_16X);

  if (BAUD_RATE == 0 || OVERSAMPLING == 0) begin : g_bad_rate
    $error("baud_rate_gen: BAUD_RATE and OVERSAMPLING must be nonzero");
  end

  if (CLK_FREQ_HZ < BAUD_RATE * OVERSAMPLING) begin : g_bad_clk
    $error("baud_rate_gen: CLK_FREQ_HZ below BAUD_RATE*OVERSAMPLING");
  end

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW16-1:0] cnt_16x_q, cnt_16x_d;
  logic            tick_q, tick_d;
  logic            tick_16x_q, tick_16x_d;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == CMAX) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_16x_d  = '0;
    tick_16x_d = 1'b0;
    if (enable) begin
      if (cnt_16x_q == CMAX16) begin
        tick_16x_d = 1'b1;
      end else begin
        cnt_16x_d = cnt_16x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cnt_16x_q  <= '0;
      tick_q     <= 1'b0;
      tick_16x_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cnt_16x_q  <= cnt_16x_d;
      tick_q     <= tick_d;
      tick_16x_q <= tick_16x_d;
    end
  end

  assign tick     = tick_q;
  assign tick_16x = tick_16x_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Bench for baud_rate_gen: 50 MHz / 9600 main instance with a
// pulse scoreboard, plus a 16 Hz / 1 baud instance with a zero divider.
module tb_baud_rate_gen;

  localparam int D   = 5207;
  localparam int D16 = 324;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic en2;
  logic tick;
  logic tick_16x;
  logic tick2;
  logic tick2_16x;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int q_t[$];
  int q_s[$];
  int seen_t;
  int seen_s;
  bit et;
  bit es;

  baud_rate_gen #(
    .CLK_FREQ_HZ (50_000_000),
    .BAUD_RATE   (9600),
    .OVERSAMPLING(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (en),
    .tick    (tick),
    .tick_16x(tick_16x)
  );

  baud_rate_gen #(
    .CLK_FREQ_HZ (16),
    .BAUD_RATE   (1),
    .OVERSAMPLING(16)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (en2),
    .tick    (tick2),
    .tick_16x(tick2_16x)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Expected pulse edges are queued by the stimulus; any high
  // output or due entry is checked at the negedge after its edge.
  always @(negedge clk) begin
    et = (q_t.size() > 0) && (q_t[0] == cyc);
    es = (q_s.size() > 0) && (q_s[0] == cyc);
    if (et) void'(q_t.pop_front());
    if (es) void'(q_s.pop_front());
    if (tick) seen_t++;
    if (tick_16x) seen_s++;
    if (tick || et) chk("tick_pulse", 32'(tick), 32'(et));
    if (tick_16x || es) chk("tick16x_pulse", 32'(tick_16x), 32'(es));
  end

  typedef struct {
    int n;
    bit by_rst;
    int hold;
    int exp_t;
    int exp_s;
  } vec_t;

  task automatic window(vec_t v, string nm);
    int c;
    c = cyc;
    for (int e = c + 1 + D; e <= c + v.n; e += D + 1)
      q_t.push_back(e);
    for (int e = c + 1 + D16; e <= c + v.n; e += D16 + 1)
      q_s.push_back(e);
    seen_t = 0;
    seen_s = 0;
    en = 1'b1;
    repeat (v.n) @(negedge clk);
    if (v.by_rst) begin
      #2 rst_n = 1'b0;
      #1;
      chk({nm, "_rst_tick"}, 32'(tick), 0);
      chk({nm, "_rst_tick16x"}, 32'(tick_16x), 0);
      chk({nm, "_rst_cnt"}, 32'(dut.cnt_q), 0);
      repeat (v.hold) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      en = 1'b0;
      repeat (v.hold) @(negedge clk);
      chk({nm, "_dis_cnt"}, 32'(dut.cnt_q), 0);
      chk({nm, "_dis_cnt16x"}, 32'(dut.cnt_16x_q), 0);
    end
    chk({nm, "_ntick"}, seen_t, v.exp_t);
    chk({nm, "_ntick16x"}, seen_s, v.exp_s);
  endtask

  initial begin
    vec_t tbl[4];
    int c;
    tbl[0] = '{26040, 1'b0, 15624, 5, 80};
    tbl[1] = '{5850,  1'b0, 200,   1, 18};
    tbl[2] = '{2600,  1'b1, 3,     0, 8};
    tbl[3] = '{5208,  1'b0, 10,    1, 16};

    rst_n = 1'b0;
    en    = 1'b0;
    en2   = 1'b0;
    repeat (2) @(negedge clk);
    #5;
    chk("reset_tick", 32'(tick), 0);
    chk("reset_tick16x", 32'(tick_16x), 0);
    chk("reset_cnt", 32'(dut.cnt_q), 0);
    chk("reset_cnt16x", 32'(dut.cnt_16x_q), 0);
    chk("reset_tick2_16x", 32'(tick2_16x), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++)
      window(tbl[i], $sformatf("win%0d", i));

    chk("tick_left", q_t.size(), 0);
    chk("tick16x_left", q_s.size(), 0);

    c = cyc;
    en2 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("ovs0_tick16x", 32'(tick2_16x), 1);
      chk("ovs0_tick", 32'(tick2),
          (i % 16 == 0) ? 32'd1 : 32'd0);
    end
    chk("ovs0_cycles", cyc - c, 40);
    en2 = 1'b0;
    @(negedge clk);
    chk("ovs0_off_tick16x", 32'(tick2_16x), 0);
    chk("ovs0_off_tick", 32'(tick2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baud_rate_gen.md
# baud_rate_gen

Free-running baud-rate tick generator for the UART. Divides the system clock into two single-cycle strobes: `tick` at the bit rate and `tick_16x` at the oversampled rate. The transmitter consumes `tick`; the receiver consumes `tick_16x`. Both counters run only while `enable` is high.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate in baud.
- `OVERSAMPLING`, default 16: receiver oversampling factor.
- Derived localparams, using truncating integer division:
  - `BAUD_DIV` = CLK_FREQ_HZ / BAUD_RATE − 1
  - `BAUD_DIV_16X` = CLK_FREQ_HZ / (BAUD_RATE·OVERSAMPLING) − 1

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run/stop control for both dividers.
- `tick`  out  1  one-clock pulse every BAUD_DIV+1 cycles.
- `tick_16x`  out  1  one-clock pulse every BAUD_DIV_16X+1 cycles.

## Operation
- There are two independent counters, `cnt` and `cnt_16x`.
  - Widths are $clog2(BAUD_DIV+1) and $clog2(BAUD_DIV_16X+1), with a minimum width of 1.
  - Both are unsigned.
- At each rising edge with `enable`=1, for the bit-rate divider:
  - if `cnt`==BAUD_DIV: `cnt`←0 and `tick`←1;
  - otherwise `cnt`←`cnt`+1 and `tick`←0.
- The `tick_16x` path is identical, using BAUD_DIV_16X.
- At each rising edge with `enable`=0: both counters ←0 and both outputs ←0.
  - Disabling therefore restarts phase; it does not pause the count.
- The two counters have no phase relationship. `tick` is not required to coincide with any `tick_16x`.
  - Example: for 50 MHz / 9600, 16·325 = 5200 ≠ 5208.
- Outputs are registered and glitch-free. No combinational path exists from `enable` to the outputs.
- Elaboration checks, which must raise `$error`/`$fatal`:
  - BAUD_RATE = 0 or OVERSAMPLING = 0;
  - CLK_FREQ_HZ < BAUD_RATE·OVERSAMPLING, which would make BAUD_DIV_16X negative.
- Rate error comes from truncation only. No fractional accumulation is performed.

## Timing
- Reset (`rst_n`=0, asynchronous): `cnt`=0, `cnt_16x`=0, `tick`=0, `tick_16x`=0 immediately, held until release.
- After `rst_n` deasserts, behaviour follows `enable` from the next rising edge.
- First pulse after `enable` rises from a cleared state:
  - `tick` is high for the single cycle following the (BAUD_DIV+1)th enabled edge;
  - `tick_16x` likewise after BAUD_DIV_16X+1 enabled edges.
- Steady state:
  - `tick` rising edges are exactly (BAUD_DIV+1)·T_clk apart;
  - `tick_16x` rising edges are exactly (BAUD_DIV_16X+1)·T_clk apart;
  - each pulse is exactly one clock wide.
- `enable` falling:
  - outputs are 0 from the first edge sampling `enable`=0;
  - a pulse already high is cleared at that edge.
- `enable` re-asserted: the first pulse comes a full period later, never a partial one.
- Degenerate divider of 0 (e.g. CLK = BAUD·OVS): `tick_16x` is high on every enabled cycle.

## Test plan
- 50 MHz, BAUD_RATE=9600, OVS=16, reset 100 ns, `enable`=1 after 200 ns:
  - BAUD_DIV=5207 and BAUD_DIV_16X=324;
  - `tick` period = 104160 ns, average error vs 104166.67 ns < 0.01 %;
  - `tick_16x` period = 6500 ns, error vs 6510.42 ns ≈ −0.16 %.
- Pulse width: every `tick` and `tick_16x` high phase lasts exactly 20 ns (one clock); over 20 bit times, ≥19 `tick` periods are measured.
- Disable: drop `enable` mid-count and wait 5 bit times → `tick` and `tick_16x` stay 0 throughout; the counters read 0.
- Re-enable: the first `tick` follows `enable` by 5208 clocks and the first `tick_16x` by 325 clocks, with no early partial pulse.
- Asynchronous reset: assert `rst_n`=0 mid-period while `enable`=1 → outputs 0 at once. After release, the first `tick` arrives 5208 clocks later.
- Alternate parameters CLK=16, BAUD=1, OVS=16 (divider 0 for `tick_16x`) → `tick_16x` is high every cycle and `tick` pulses every 16 clocks.
